// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : Fetch-stage bus bundle: imem request/response, redirect, decode.
// Revision : 1.0
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req_valid;
  logic [PC_WIDTH-1:0]    imem_req_addr;
  logic                   imem_req_ready;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner, single-outstanding imem fetcher and prefetch FIFO.
//            Optional stall counter enabled by FETCH_STALL_COUNT_EN.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 2,
  parameter int RESET_PC    = 0,
  parameter int PC_STEP     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_unit_if.master bus
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [INSTR_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] data_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    pc_q   [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    pc_d   [FIFO_DEPTH];

  logic push, pop, req_valid, out_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    // Held low while in reset so the bus sees a quiet master.
    req_valid  = reset_n && (state_q == ST_IDLE) &&
                 (count_q < CNT_W'(FIFO_DEPTH)) && !bus.redirect_valid;
    out_valid  = (count_q != '0) && !bus.redirect_valid;
    pop        = out_valid && bus.instr_ready;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && bus.imem_req_ready) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_STEP);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_resp_valid) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (bus.imem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A response landing with the redirect retires the stale request, so the
    // machine returns to IDLE from either WAIT or DROP in that case.
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      push       = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      if (state_q == ST_WAIT && !bus.imem_resp_valid) begin
        state_d = ST_DROP;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    if (push) begin
      data_d[wr_ptr_q] = bus.imem_resp_data;
      pc_d[wr_ptr_q]   = req_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= PC_WIDTH'(RESET_PC);
      req_pc_q   <= PC_WIDTH'(RESET_PC);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = out_valid;
  assign bus.instr_data     = data_q[rd_ptr_q];
  assign bus.instr_pc       = pc_q[rd_ptr_q];

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.instr_ready && !out_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed scoreboard bench for instr_fetch_unit with an imem model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;
  localparam int PW = 16;
  localparam int IW = 32;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct packed {
    logic [IW-1:0] data;
    logic [PW-1:0] pc;
  } exp_t;
  exp_t exp_q[$];

  logic          mem_busy, mem_stale, ovr_en;
  int            mem_cnt, mem_lat;
  logic [PW-1:0] mem_addr, exp_pc;
  logic [IW-1:0] mem_data, ovr_data;

  instr_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  instr_fetch_unit #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .FIFO_DEPTH(2), .RESET_PC(0), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [IW-1:0] data_of(logic [PW-1:0] a);
    return {a, 16'h000B};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and memory bookkeeping for the current (settled) cycle.
  task automatic sb_step();
    exp_t e;
    if (reset_n) begin
      if (bus.instr_valid && bus.instr_ready) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pop_data", bus.instr_data, e.data);
          chk("pop_pc", bus.instr_pc, e.pc);
        end
      end
      if (bus.imem_resp_valid && !mem_stale && !bus.redirect_valid)
        exp_q.push_back({mem_data, mem_addr});
      if (bus.redirect_valid) begin
        exp_q.delete();
        exp_pc = bus.redirect_pc;
        if (mem_busy && !bus.imem_resp_valid) mem_stale = 1'b1;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("single_outstanding", mem_busy, 1'b0);
        chk("req_addr", bus.imem_req_addr, exp_pc);
        exp_pc   = bus.imem_req_addr + 16'd4;
        mem_busy = 1'b1;
        mem_addr = bus.imem_req_addr;
        mem_cnt  = mem_lat;
      end
    end
  endtask

  task automatic mem_update();
    if (bus.imem_resp_valid) begin
      bus.imem_resp_valid = 1'b0;
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        mem_data = ovr_en ? ovr_data : data_of(mem_addr);
        ovr_en   = 1'b0;
        bus.imem_resp_data  = mem_data;
        bus.imem_resp_valid = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    #1;
    sb_step();
    @(posedge clk);
    @(negedge clk);
    mem_update();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    mem_busy = 1'b0; mem_stale = 1'b0; ovr_en = 1'b0;
    exp_q.delete();
    exp_pc = 16'h0000;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_req_addr", bus.imem_req_addr, 16'h0000);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_instr_data", bus.instr_data, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 16'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic drain();
    bus.instr_ready    = 1'b1;
    bus.imem_req_ready = 1'b0;
    repeat (8) cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_instr_valid", bus.instr_valid, 1'b0);
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!bus.instr_valid && n < budget) begin
      cyc();
      n++;
    end
    chk("wait_instr_valid", bus.instr_valid, 1'b1);
  endtask

  initial begin
    reset_n = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    mem_lat = 1; mem_cnt = 0; mem_data = '0; mem_addr = '0;
    ovr_en = 1'b0; ovr_data = '0; mem_busy = 1'b0; mem_stale = 1'b0;
    #1 reset_n = 1'b0;

    // Basic fetch latency with a 1-cycle memory.
    do_reset();
    chk("t1_c1_req_valid", bus.imem_req_valid, 1'b1);
    chk("t1_c1_req_addr", bus.imem_req_addr, 16'h0000);
    cyc();
    chk("t1_c2_req_valid", bus.imem_req_valid, 1'b0);
    chk("t1_c2_instr_valid", bus.instr_valid, 1'b0);
    cyc();
    chk("t1_c3_instr_valid", bus.instr_valid, 1'b1);
    chk("t1_c3_instr_data", bus.instr_data, 32'h0000000B);
    chk("t1_c3_instr_pc", bus.instr_pc, 16'h0000);
    chk("t1_c3_req_addr", bus.imem_req_addr, 16'h0004);
    repeat (10) cyc();
    drain();

    // Backpressure fills the FIFO and stalls requests.
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    do_reset();
    repeat (4) cyc();
    chk("t2_full_req_valid", bus.imem_req_valid, 1'b0);
    chk("t2_full_instr_pc", bus.instr_pc, 16'h0000);
    repeat (2) cyc();
    chk("t2_hold_req_valid", bus.imem_req_valid, 1'b0);
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    #1;
    chk("t2_after_pop_req_valid", bus.imem_req_valid, 1'b1);
    chk("t2_after_pop_req_addr", bus.imem_req_addr, 16'h0008);
    chk("t2_after_pop_instr_pc", bus.instr_pc, 16'h0004);
    drain();
    chk("t2_stable_req_valid", bus.imem_req_valid, 1'b1);
    chk("t2_stable_req_addr", bus.imem_req_addr, 16'h0008);

    // Redirect while WAIT; stale response arrives later and is dropped.
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    mem_lat = 3;
    do_reset();
    chk("t3_c1_req_addr", bus.imem_req_addr, 16'h0000);
    cyc();
    mem_lat  = 1;
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD0013;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0040;
    #1;
    chk("t3_redir_instr_valid", bus.instr_valid, 1'b0);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_drop_req_valid", bus.imem_req_valid, 1'b0);
    cyc();
    chk("t3_stale_resp_req_valid", bus.imem_req_valid, 1'b0);
    cyc();
    chk("t3_new_req_valid", bus.imem_req_valid, 1'b1);
    chk("t3_new_req_addr", bus.imem_req_addr, 16'h0040);
    wait_valid(20);
    chk("t3_first_pc", bus.instr_pc, 16'h0040);
    chk("t3_first_data", bus.instr_data, 32'h0040000B);
    drain();

    // Redirect coinciding with a response and a buffered entry.
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    mem_lat = 1;
    do_reset();
    repeat (3) cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0080;
    bus.instr_ready    = 1'b1;
    #1;
    chk("t4_redir_instr_valid", bus.instr_valid, 1'b0);
    cyc();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    #1;
    chk("t4_flushed_instr_valid", bus.instr_valid, 1'b0);
    chk("t4_next_req_valid", bus.imem_req_valid, 1'b1);
    chk("t4_next_req_addr", bus.imem_req_addr, 16'h0080);
    repeat (4) cyc();
    chk("t4_full_instr_valid", bus.instr_valid, 1'b1);
    chk("t4_full_req_valid", bus.imem_req_valid, 1'b0);
    chk("t4_full_instr_pc", bus.instr_pc, 16'h0080);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0100;
    bus.instr_ready    = 1'b1;
    #1;
    chk("t4_full_redir_instr_valid", bus.instr_valid, 1'b0);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_full_flushed_valid", bus.instr_valid, 1'b0);
    chk("t4_full_next_addr", bus.imem_req_addr, 16'h0100);
    drain();

    // PC wrap at the top of the address space.
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFC;
    #1;
    chk("t5_idle_redir_req_valid", bus.imem_req_valid, 1'b0);
    cyc();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_req_fffc", bus.imem_req_addr, 16'hFFFC);
    cyc();
    cyc();
    chk("t5_wrap_req_valid", bus.imem_req_valid, 1'b1);
    chk("t5_wrap_req_addr", bus.imem_req_addr, 16'h0000);
    drain();

    // Response with nothing outstanding after reset is ignored.
    bus.imem_req_ready = 1'b0;
    bus.instr_ready    = 1'b1;
    do_reset();
    mem_stale = 1'b1;
    bus.imem_resp_data  = 32'h12345678;
    bus.imem_resp_valid = 1'b1;
    cyc();
    cyc();
    chk("t6_ignored_instr_valid", bus.instr_valid, 1'b0);
    chk("t6_ignored_req_addr", bus.imem_req_addr, 16'h0000);

`ifdef FETCH_STALL_COUNT_EN
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    mem_lat = 3;
    do_reset();
    wait_valid(20);
    chk("t7_stall_cycles", stall_cycles, 32'd4);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage directly upstream of the control unit and decode.
- Owns the program counter and issues word requests to instruction memory over a valid/ready request plus valid response interface.
- Buffers returned instructions in a small prefetch FIFO, then presents {instr, pc} to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump target) from execute, which flushes all wrong-path state.

Parameters:
- PC_WIDTH, 16: width of the PC and of instruction memory addresses, in bytes.
- INSTR_WIDTH, 32: instruction word width. Opcode is [6:0], funct3 is [14:12], funct7 is [31:25].
- FIFO_DEPTH, 2: prefetch buffer entries. Must be a power of 2, at least 2.
- RESET_PC, 0: PC value loaded at reset.
- PC_STEP, 4: PC increment per fetched word.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  PC_WIDTH  fetch byte address.
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  response data valid. Single cycle, in request order.
- imem_resp_data  in  INSTR_WIDTH  returned instruction word.
- redirect_valid  in  1  load a new PC and flush.
- redirect_pc  in  PC_WIDTH  redirect target.
- instr_valid  out  1  head of the FIFO is valid for decode.
- instr_data  out  INSTR_WIDTH  head instruction.
- instr_pc  out  PC_WIDTH  PC of the head instruction.
- instr_ready  in  1  decode consumes the head.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - fetch_pc = RESET_PC, FIFO empty, state = IDLE.
  - instr_valid = 0, imem_req_valid = 0, imem_req_addr = RESET_PC, instr_data = 0, instr_pc = 0.
- Reset asserted mid-operation aborts everything immediately. A response arriving after reset deasserts with no outstanding request is ignored.
- States: IDLE (no request outstanding), WAIT (one request accepted, awaiting response), DROP (one stale request outstanding, its response will be discarded).
- IDLE:
  - imem_req_valid = (count < FIFO_DEPTH) and !redirect_valid. imem_req_addr = fetch_pc.
  - On valid & ready: req_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP (wraps modulo 2^PC_WIDTH), go to WAIT.
  - Address and valid stay stable while valid & !ready, unless a redirect occurs.
- WAIT:
  - No new request is issued.
  - On imem_resp_valid: push {imem_resp_data, req_pc}, go to IDLE.
  - At most one request is ever outstanding, so peak throughput is 1 instruction per 2 cycles.
- DROP: on imem_resp_valid, discard the data and go to IDLE. No FIFO push.
- Redirect (any state, highest priority):
  - fetch_pc <= redirect_pc and the FIFO is flushed (count <= 0).
  - instr_valid is forced 0 combinationally in the redirect cycle, so no transfer happens that cycle.
  - From WAIT, go to DROP, unless imem_resp_valid arrives the same cycle; then the response is discarded and the state goes to IDLE.
  - From IDLE, no request is issued that cycle. Stay IDLE; the next request uses redirect_pc.
  - From DROP, stay DROP, with fetch_pc updated.
- FIFO:
  - instr_valid = (count != 0) and !redirect_valid. instr_data and instr_pc come from the head entry.
  - Pop occurs on instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push never occurs when full, because requests are gated on count < FIFO_DEPTH.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency: with a 1-cycle memory (ready=1, response the cycle after acceptance), the first instruction is visible at instr_valid 2 cycles after the first request cycle.

Optional Feature:
- Macro: FETCH_STALL_COUNT_EN.
- With the macro defined:
  - Extra output port stall_cycles (out, 32 bits).
  - Increments every cycle that instr_ready=1 and instr_valid=0. Saturates at 0xFFFFFFFF.
  - Cleared to 0 on reset. Not cleared by redirect.
- Without the macro: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset release, 1-cycle memory returning 0x0000000B at 0x0000, instr_ready=1 -> request addr 0x0000 in cycle 1; instr_valid=1 in cycle 3 with instr_data=0x0000000B, instr_pc=0x0000; next request addr 0x0004.
- instr_ready=0, memory always ready -> exactly 2 instructions buffered (pc 0x0000, 0x0004); imem_req_valid stays 0 until one pop; the next request is addr 0x0008.
- Redirect to 0x0040 while in WAIT, response arriving 3 cycles later with 0xDEAD0013 -> that data is never presented; the next request is addr 0x0040; the first valid instr_pc=0x0040.
- Redirect coinciding with imem_resp_valid and with a full FIFO plus instr_ready=1 -> instr_valid=0 that cycle, FIFO empty next cycle, next request addr = redirect_pc.
- fetch_pc=0xFFFC with PC_WIDTH=16 -> request at 0xFFFC is followed by a request at 0x0000.
- FETCH_STALL_COUNT_EN defined, instr_ready=1 from reset with a 3-cycle memory latency -> stall_cycles=4 when the first instr_valid rises (the 1-cycle issue delay after reset plus 3 cycles of memory latency).
